rom_write_ctrl: RTL and testbench

Front-end write controller that sits directly upstream of the 32×8 store block. It turns raw board pushbuttons and slide switches into clean, single-cycle `Load`/`Clear` strobes with a stable address and data. It adds an auto-incrementing write pointer and a clear-all sweep that wipes all 32 locations. Every store-facing output is registered, so the store sees glitch-free, bounce-free commands.

---
 rtl/rom_ctrl_pkg.sv | 31 +++
 rtl/rom_write_ctrl_debounce.sv | 62 ++++++
 rtl/rom_write_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rom_write_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_ctrl_pkg
// Purpose  : Shared constants and FSM state type for the store write
//            front end (rom_write_ctrl and its button conditioners).
// Contents : ADDR_W, DATA_W, DEPTH constants; state_t; request bit indices.
// Revision : 1.0 - initial release
// ============================================================================
package rom_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // Bit positions of the conditioned button requests inside the request vector
    localparam int REQ_LOAD     = 0;
    localparam int REQ_CLEAR    = 1;
    localparam int REQ_CLEARALL = 2;
    localparam int REQ_NEXT     = 3;
    localparam int REQ_PREV     = 4;
    localparam int NUM_BTN      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLR   = 2'd2,
        SWEEP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_write_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Conditions one raw pushbutton: 2-flop synchronizer, counter
//            based debounce, and a registered one-cycle rising-edge pulse.
// Ports    : CLK      - system clock, rising edge
//            Reset_n  - asynchronous active-low reset
//            i_btn    - raw, asynchronous, bouncy button level
//            o_rise   - one-cycle pulse when the debounced level goes 0->1
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_rise;
    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the run, so bounces never accumulate.
            if (r_sync2 != r_level) begin
                if (r_cnt == C_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/rom_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_write_ctrl
// Purpose  : Turns board buttons/switches into clean registered Load/Clear
//            strobes with stable address/data for the 32x8 store. Adds an
//            auto-incrementing write pointer and a clear-all sweep.
// Ports    : CLK, Reset_n                - clock, async active-low reset
//            BtnLoad/BtnClear/BtnClearAll/BtnNext/BtnPrev - raw buttons
//            AutoMode                    - 1: address from Ptr, 0: from SW_A
//            SW_A, SW_D                  - switch address / data
//            A, D, Load, Clear           - registered store command
//            Busy                        - sweep in progress
//            Ptr                         - write pointer, for display
// Revision : 1.0 - initial release
// ============================================================================
module rom_write_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ADDR_W          = rom_ctrl_pkg::ADDR_W,
    parameter int DATA_W          = rom_ctrl_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              BtnLoad,
    input  logic              BtnClear,
    input  logic              BtnClearAll,
    input  logic              BtnNext,
    input  logic              BtnPrev,
    input  logic              AutoMode,
    input  logic [ADDR_W-1:0] SW_A,
    input  logic [DATA_W-1:0] SW_D,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              Load,
    output logic              Clear,
    output logic              Busy,
    output logic [ADDR_W-1:0] Ptr
);

    import rom_ctrl_pkg::*;

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_req;

    assign w_raw = {BtnPrev, BtnNext, BtnClearAll, BtnClear, BtnLoad};

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK    (CLK),
            .Reset_n(Reset_n),
            .i_btn  (w_raw[gi]),
            .o_rise (w_req[gi])
        );
    end

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_sweep;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic              r_load;
    logic              r_clear;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_sweep_nxt;
    logic [ADDR_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_d_nxt;
    logic              w_load_nxt;
    logic              w_clear_nxt;
    logic              w_busy_nxt;
    logic [ADDR_W-1:0] w_sel_a;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sweep <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_load  <= 1'b0;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sweep <= w_sweep_nxt;
            r_a     <= w_a_nxt;
            r_d     <= w_d_nxt;
            r_load  <= w_load_nxt;
            r_clear <= w_clear_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sweep_nxt = r_sweep;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
        w_load_nxt  = 1'b0;
        w_clear_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_sel_a     = AutoMode ? r_ptr : SW_A;

        case (r_state)
            IDLE: begin
                w_a_nxt = w_sel_a;
                w_d_nxt = SW_D;
                if (w_req[REQ_CLEARALL]) begin
                    w_state_nxt = SWEEP;
                    w_sweep_nxt = '0;
                    w_a_nxt     = '0;
                    w_d_nxt     = '0;
                    w_clear_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else if (w_req[REQ_LOAD]) begin
                    // Strobe carries the address/data already on A/D this cycle
                    w_state_nxt = WRITE;
                    w_a_nxt     = r_a;
                    w_d_nxt     = r_d;
                    w_load_nxt  = 1'b1;
                end else if (w_req[REQ_CLEAR]) begin
                    w_state_nxt = CLR;
                    w_a_nxt     = r_a;
                    w_d_nxt     = r_d;
                    w_clear_nxt = 1'b1;
                end else if (w_req[REQ_NEXT]) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end else if (w_req[REQ_PREV]) begin
                    w_ptr_nxt = r_ptr - 1'b1;
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
                if (AutoMode) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            CLR: begin
                w_state_nxt = IDLE;
            end
            SWEEP: begin
                if (r_sweep == {ADDR_W{1'b1}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_sweep_nxt = r_sweep + 1'b1;
                    w_a_nxt     = r_sweep + 1'b1;
                    w_clear_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign A     = r_a;
    assign D     = r_d;
    assign Load  = r_load;
    assign Clear = r_clear;
    assign Busy  = r_busy;
    assign Ptr   = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rom_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_write_ctrl
// Purpose  : Self-checking bench for rom_write_ctrl with DEBOUNCE_CYCLES=4:
//            vector table, randomized presses against a transaction-level
//            pointer/strobe model, and hand sequences for bounce, sweep,
//            priority and reset-mid-sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_write_ctrl;

    localparam int DB = 4;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       BtnLoad = 1'b0;
    logic       BtnClear = 1'b0;
    logic       BtnClearAll = 1'b0;
    logic       BtnNext = 1'b0;
    logic       BtnPrev = 1'b0;
    logic       AutoMode = 1'b0;
    logic [4:0] SW_A = '0;
    logic [7:0] SW_D = '0;
    logic [4:0] A;
    logic [7:0] D;
    logic       Load;
    logic       Clear;
    logic       Busy;
    logic [4:0] Ptr;

    rom_write_ctrl #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .BtnLoad    (BtnLoad),
        .BtnClear   (BtnClear),
        .BtnClearAll(BtnClearAll),
        .BtnNext    (BtnNext),
        .BtnPrev    (BtnPrev),
        .AutoMode   (AutoMode),
        .SW_A       (SW_A),
        .SW_D       (SW_D),
        .A          (A),
        .D          (D),
        .Load       (Load),
        .Clear      (Clear),
        .Busy       (Busy),
        .Ptr        (Ptr)
    );

    always #5 CLK = ~CLK;

    // Button mask bits: 0 Load, 1 Clear, 2 ClearAll, 3 Next, 4 Prev
    typedef struct {
        logic       ld;
        logic       cl;
        logic       bz;
        logic [4:0] a;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [4:0] btn;
        logic       am;
        logic [4:0] swa;
        logic [7:0] swd;
        int         nld;
        int         ncl;
        int         ea;
        int         ed;
        int         eptr;
    } vec_t;

    ev_t  evq[$];
    int   both_cnt = 0;
    int   total = 0;
    int   bad = 0;
    int   mptr = 0;
    vec_t tbl[13];

    always @(negedge CLK) begin
        if (Load || Clear) evq.push_back(ev_t'{Load, Clear, Busy, A, D});
        if (Load && Clear) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] m);
        {BtnPrev, BtnNext, BtnClearAll, BtnClear, BtnLoad} = m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge CLK);
        set_btn(m);
        repeat (10) @(negedge CLK);
        set_btn(5'd0);
        repeat (m[2] ? 50 : 16) @(negedge CLK);
    endtask

    task automatic count_ev(output int nl, output int nc);
        nl = 0;
        nc = 0;
        foreach (evq[i]) begin
            if (evq[i].ld) nl++;
            if (evq[i].cl) nc++;
        end
    endtask

    task automatic check_sweep(input string nm);
        for (int i = 0; i < 32 && i < evq.size(); i++) begin
            check({nm, " sweep A"}, 32'(evq[i].a), 32'(i));
            check({nm, " sweep D"}, 32'(evq[i].d), 32'd0);
            check({nm, " sweep Busy"}, 32'(evq[i].bz), 32'd1);
        end
    endtask

    task automatic run_vec(input string nm, input logic [4:0] m, input logic am,
                           input logic [4:0] swa, input logic [7:0] swd,
                           input int enl, input int encl, input int ea,
                           input int ed, input int eptr);
        int nl, nc;
        @(negedge CLK);
        AutoMode = am;
        SW_A = swa;
        SW_D = swd;
        repeat (3) @(negedge CLK);
        evq.delete();
        press(m);
        count_ev(nl, nc);
        check({nm, " loads"}, 32'(nl), 32'(enl));
        check({nm, " clears"}, 32'(nc), 32'(encl));
        if (enl + encl == 1 && evq.size() == 1) begin
            check({nm, " A"}, 32'(evq[0].a), 32'(ea));
            check({nm, " D"}, 32'(evq[0].d), 32'(ed));
        end
        if (encl == 32) check_sweep(nm);
        check({nm, " Ptr"}, 32'(Ptr), 32'(eptr));
    endtask

    initial begin
        int nl, nc, found;
        logic [4:0] m;
        logic       am;
        logic [4:0] swa;
        logic [7:0] swd;
        int         enl, encl, ea, ed;

        // btn, am, swa, swd, nld, ncl, ea, ed, eptr
        tbl[0]  = '{5'd1,  1'b0, 5'd5,  8'hA5, 1, 0, 5,  'hA5, 0};
        tbl[1]  = '{5'd16, 1'b0, 5'd0,  8'h00, 0, 0, 0,  0,    31};
        tbl[2]  = '{5'd8,  1'b0, 5'd0,  8'h00, 0, 0, 0,  0,    0};
        tbl[3]  = '{5'd2,  1'b0, 5'd9,  8'h3C, 0, 1, 9,  'h3C, 0};
        tbl[4]  = '{5'd16, 1'b0, 5'd0,  8'h00, 0, 0, 0,  0,    31};
        tbl[5]  = '{5'd16, 1'b0, 5'd0,  8'h00, 0, 0, 0,  0,    30};
        tbl[6]  = '{5'd1,  1'b1, 5'd0,  8'h11, 1, 0, 30, 'h11, 31};
        tbl[7]  = '{5'd1,  1'b1, 5'd0,  8'h22, 1, 0, 31, 'h22, 0};
        tbl[8]  = '{5'd1,  1'b1, 5'd0,  8'h33, 1, 0, 0,  'h33, 1};
        tbl[9]  = '{5'd2,  1'b1, 5'd7,  8'h44, 0, 1, 1,  'h44, 1};
        tbl[10] = '{5'd8,  1'b1, 5'd0,  8'h00, 0, 0, 0,  0,    2};
        tbl[11] = '{5'd9,  1'b0, 5'd3,  8'h55, 1, 0, 3,  'h55, 2};
        tbl[12] = '{5'd18, 1'b0, 5'd20, 8'h66, 0, 1, 20, 'h66, 2};

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset A", 32'(A), 0);
        check("reset D", 32'(D), 0);
        check("reset Load", 32'(Load), 0);
        check("reset Clear", 32'(Clear), 0);
        check("reset Busy", 32'(Busy), 0);
        check("reset Ptr", 32'(Ptr), 0);
        Reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("post-reset Load", 32'(Load), 0);
        check("post-reset Ptr", 32'(Ptr), 0);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].btn, tbl[i].am, tbl[i].swa,
                    tbl[i].swd, tbl[i].nld, tbl[i].ncl, tbl[i].ea, tbl[i].ed,
                    tbl[i].eptr);
        end
        mptr = 2;

        // Randomized presses against a transaction-level model
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      m = 5'd1;
            else if (r < 5) m = 5'd2;
            else if (r < 7) m = 5'd8;
            else if (r < 9) m = 5'd16;
            else            m = 5'($urandom_range(1, 31));
            am  = 1'($urandom_range(0, 1));
            swa = 5'($urandom_range(0, 31));
            swd = 8'($urandom_range(0, 255));
            enl = 0; encl = 0; ea = 0; ed = 0;
            if (m[2]) begin
                encl = 32;
            end else if (m[0]) begin
                enl = 1;
                ea  = am ? mptr : int'(swa);
                ed  = int'(swd);
                if (am) mptr = (mptr + 1) % 32;
            end else if (m[1]) begin
                encl = 1;
                ea   = am ? mptr : int'(swa);
                ed   = int'(swd);
            end else if (m[3]) begin
                mptr = (mptr + 1) % 32;
            end else if (m[4]) begin
                mptr = (mptr + 31) % 32;
            end
            run_vec($sformatf("rnd%0d", it), m, am, swa, swd, enl, encl, ea, ed, mptr);
        end

        // Bounce rejection, then long hold
        @(negedge CLK);
        AutoMode = 1'b0;
        SW_A = 5'd12;
        SW_D = 8'h5A;
        repeat (3) @(negedge CLK);
        evq.delete();
        for (int i = 0; i < 20; i++) begin
            BtnLoad = ((i / 2) % 2) == 0;
            @(negedge CLK);
        end
        BtnLoad = 1'b1;
        repeat (20) @(negedge CLK);
        count_ev(nl, nc);
        check("bounce loads", 32'(nl), 1);
        if (evq.size() == 1) begin
            check("bounce A", 32'(evq[0].a), 12);
            check("bounce D", 32'(evq[0].d), 'h5A);
        end
        evq.delete();
        repeat (100) @(negedge CLK);
        check("hold events", 32'(evq.size()), 0);
        BtnLoad = 1'b0;
        repeat (16) @(negedge CLK);

        // Sweep with a Load press arriving mid-sweep
        evq.delete();
        AutoMode = 1'b1;
        set_btn(5'd4);
        repeat (10) @(negedge CLK);
        set_btn(5'd1);
        repeat (10) @(negedge CLK);
        set_btn(5'd0);
        repeat (50) @(negedge CLK);
        count_ev(nl, nc);
        check("sweep+load loads", 32'(nl), 0);
        check("sweep+load clears", 32'(nc), 32);
        check_sweep("sweep+load");
        check("sweep+load Ptr", 32'(Ptr), 32'(mptr));
        check("sweep end Busy", 32'(Busy), 0);

        // Simultaneous ClearAll and Load
        run_vec("prio", 5'd5, 1'b0, 5'd3, 8'h77, 0, 32, 0, 0, mptr);

        // Reset asserted at sweep address 10
        evq.delete();
        set_btn(5'd4);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge CLK);
            if (i == 9) set_btn(5'd0);
            if (Clear === 1'b1 && A == 5'd10) found = 1;
        end
        set_btn(5'd0);
        check("reach sweep addr 10", 32'(found), 1);
        #1 Reset_n = 1'b0;
        #1;
        check("rst-mid A", 32'(A), 0);
        check("rst-mid Clear", 32'(Clear), 0);
        check("rst-mid Busy", 32'(Busy), 0);
        check("rst-mid Load", 32'(Load), 0);
        check("rst-mid Ptr", 32'(Ptr), 0);
        mptr = 0;
        repeat (3) @(negedge CLK);
        evq.delete();
        Reset_n = 1'b1;
        repeat (60) @(negedge CLK);
        check("post-rst events", 32'(evq.size()), 0);
        check("post-rst Busy", 32'(Busy), 0);

        check("Load&Clear overlap", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
